spike_aer_scheduler: RTL

SPIKE_AER_SCHEDULER -- requirements
Module: spike_aer_scheduler

---
 rtl/spike_aer_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/spike_aer_scheduler.sv
// Collects input spikes per timestep and drains a frozen snapshot as round-robin AER events.
// state | meaning: IDLE = collecting, waiting ts_start | DRAIN = emitting snapshot events | DONE = ts_done pulse
module spike_aer_scheduler #(
    parameter int NUM_INPUTS = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int DROP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] spike_in,
    input  logic                  ts_start,
    output logic                  aer_valid,
    input  logic                  aer_ready,
    output logic [ADDR_WIDTH-1:0] aer_addr,
    output logic                  ts_done,
    output logic                  busy,
    output logic [DROP_WIDTH-1:0] drop_count
);

    localparam int SW = DROP_WIDTH + 7;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

    state_t                  state_q;
    logic [NUM_INPUTS-1:0]   pending_q, active_q;
    logic [ADDR_WIDTH-1:0]   rr_ptr_q, aer_addr_q;
    logic                    aer_valid_q, ts_done_q, busy_q;
    logic [DROP_WIDTH-1:0]   drop_count_q;

    logic                    snap, accept, found, hi_found, lo_found;
    logic [NUM_INPUTS-1:0]   accept_mask, active_m, collide, pending_d;
    logic [ADDR_WIDTH-1:0]   hi_idx, lo_idx, cand, rr_next;
    logic [6:0]              n_drop;
    logic [SW-1:0]           drop_sum;
    logic [DROP_WIDTH-1:0]   drop_count_d;

    always_comb begin
        snap        = (state_q == S_IDLE) && ts_start;
        accept      = aer_valid_q && aer_ready;
        accept_mask = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            accept_mask[i] = accept && (aer_addr_q == ADDR_WIDTH'(i));
        active_m = active_q & ~accept_mask;

        // Scan downward so the last hit is the lowest index; the ">= rr_ptr" hit wins over the wrapped one.
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (active_m[i]) begin
                lo_found = 1'b1;
                lo_idx   = ADDR_WIDTH'(i);
                if (ADDR_WIDTH'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ADDR_WIDTH'(i);
                end
            end
        end
        found   = lo_found;
        cand    = hi_found ? hi_idx : lo_idx;
        rr_next = (aer_addr_q == ADDR_WIDTH'(NUM_INPUTS - 1)) ? '0 : aer_addr_q + ADDR_WIDTH'(1);

        collide = spike_in & pending_q;
        n_drop  = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            n_drop = n_drop + 7'(collide[i]);
        drop_sum = SW'(drop_count_q) + SW'(n_drop);

        // On a snapshot edge pending is being handed over, so nothing collides.
        pending_d = snap ? spike_in : (pending_q | spike_in);
        if (snap)
            drop_count_d = drop_count_q;
        else if (drop_sum[SW-1:DROP_WIDTH] != '0)
            drop_count_d = '1;
        else
            drop_count_d = drop_sum[DROP_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            active_q     <= '0;
            rr_ptr_q     <= '0;
            aer_valid_q  <= 1'b0;
            aer_addr_q   <= '0;
            ts_done_q    <= 1'b0;
            busy_q       <= 1'b0;
            drop_count_q <= '0;
        end else begin
            pending_q    <= pending_d;
            drop_count_q <= drop_count_d;
            if (accept)
                rr_ptr_q <= rr_next;
            case (state_q)
                S_IDLE: begin
                    if (ts_start) begin
                        active_q <= pending_q;
                        state_q  <= S_DRAIN;
                        busy_q   <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    active_q <= active_m;
                    if (!aer_valid_q || accept) begin
                        if (found) begin
                            aer_valid_q <= 1'b1;
                            aer_addr_q  <= cand;
                        end else begin
                            aer_valid_q <= 1'b0;
                            state_q     <= S_DONE;
                            ts_done_q   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    ts_done_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign aer_valid  = aer_valid_q;
    assign aer_addr   = aer_addr_q;
    assign ts_done    = ts_done_q;
    assign busy       = busy_q;
    assign drop_count = drop_count_q;

endmodule
